// File: rtl/word_packer.sv
// word_packer: packs MAC bytes big-endian into 32-bit matcher words.
// Define WORD_PACKER_FLUSH_EN to append five zero words before clear.
module word_packer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_eop,
  output logic        byte_ready,
  output logic [31:0] data_out,
  output logic        word_valid,
  output logic        clear
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH,
    CLR
  } state_t;

  localparam logic [2:0] FLUSH_LAST = 3'd4;

  state_t      state_q, state_d;
  state_t      eop_dest;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] part_q, part_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        live_q;
  logic [31:0] data_q, data_d;
  logic        wv_q, wv_d;
  logic        clr_q, clr_d;
  logic        xfer;
  logic        close;
  logic [31:0] word;

`ifdef WORD_PACKER_FLUSH_EN
  assign eop_dest = FLUSH;
`else
  assign eop_dest = CLR;
`endif

  assign byte_ready = live_q &
                      ((state_q == IDLE) | (state_q == FILL));
  assign xfer  = byte_valid & byte_ready;
  assign close = xfer & (byte_eop | (lane_q == 2'd3));

  assign data_out   = data_q;
  assign word_valid = wv_q;
  assign clear      = clr_q;

  // Current word with the incoming byte dropped into its lane.
  always_comb begin
    word = 32'h0;
    unique case (lane_q)
      2'd0:    word = {byte_in, 24'h0};
      2'd1:    word = {part_q[23:16], byte_in, 16'h0};
      2'd2:    word = {part_q[23:8], byte_in, 8'h0};
      default: word = {part_q, byte_in};
    endcase
  end

  // Lane counter, partial word and flush counter next state.
  always_comb begin
    lane_d = lane_q;
    part_d = part_q;
    if (state_q == CLR) begin
      lane_d = 2'd0;
      part_d = 24'h0;
    end else if (xfer) begin
      if (close) begin
        lane_d = 2'd0;
        part_d = 24'h0;
      end else begin
        lane_d = lane_q + 2'd1;
        part_d = word[31:8];
      end
    end
    fcnt_d = (state_q == FLUSH) ? fcnt_q + 3'd1 : 3'd0;
  end

  // Packet sequencing: fill, optional flush, one clear cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (xfer) state_d = byte_eop ? eop_dest : FILL;
      FILL:  if (xfer && byte_eop) state_d = eop_dest;
      FLUSH: if (fcnt_q == FLUSH_LAST) state_d = CLR;
      CLR:   state_d = IDLE;
    endcase
  end

  // Registered outputs: closed word, flush zeros, clear pulse.
  always_comb begin
    wv_d   = close | (state_q == FLUSH);
    data_d = close ? word : 32'h0;
    clr_d  = (state_q == CLR);
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Holds byte_ready low until the first edge out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lane_q <= 2'd0;
      part_q <= 24'h0;
      fcnt_q <= 3'd0;
    end else begin
      lane_q <= lane_d;
      part_q <= part_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q <= 32'h0;
      wv_q   <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      wv_q   <= wv_d;
      clr_q  <= clr_d;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: directed and random packets against a
// cycle-indexed behavioural model of the packer.
module tb_word_packer;

  localparam int N = 16384;
`ifdef WORD_PACKER_FLUSH_EN
  localparam int FZ = 5;
`else
  localparam int FZ = 0;
`endif

  logic        clk;
  logic        n_rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_eop;
  logic        byte_ready;
  logic [31:0] data_out;
  logic        word_valid;
  logic        clear;

  word_packer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_eop   (byte_eop),
    .byte_ready (byte_ready),
    .data_out   (data_out),
    .word_valid (word_valid),
    .clear      (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit          ew  [N];
  logic [31:0] ed  [N];
  bit          ec  [N];
  bit          blk [N];
  bit          st  [N];
  int          cyc = 0;
  bit          started = 0;
  bit          last_xfer = 0;
  logic [7:0]  pb [4];
  int          pn = 0;
  logic [31:0] mwords [$];
  int          mclr = 0;
  int          mzero = 0;
  int          dclr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Reset wipes everything the model had scheduled.
  always @(negedge n_rst) begin
    for (int n = cyc; n < N; n++) begin
      ew[n] = 0; ed[n] = 32'h0; ec[n] = 0; blk[n] = 0; st[n] = 0;
    end
    started = 0;
    pn = 0;
    pb = '{default: 8'h0};
  end

  // Model: one posedge closes cycle k; schedule future outputs.
  always @(posedge clk) begin
    int k;
    logic [31:0] w;
    k = cyc;
    last_xfer = 0;
    if (n_rst && k < N - 8) begin
      if (byte_valid && st[k] && !blk[k]) begin
        last_xfer = 1;
        pb[pn] = byte_in;
        pn++;
        if (pn == 4 || byte_eop) begin
          w = {pb[0], pb[1], pb[2], pb[3]};
          ew[k+1] = 1; ed[k+1] = w;
          mwords.push_back(w);
          pn = 0;
          pb = '{default: 8'h0};
          if (byte_eop) begin
            for (int i = 1; i <= FZ; i++) begin
              ew[k+1+i] = 1; ed[k+1+i] = 32'h0; mzero++;
            end
            for (int i = 1; i <= FZ + 1; i++) blk[k+i] = 1;
            ec[k+FZ+2] = 1;
            mclr++;
          end
        end
      end
      started = 1;
    end else begin
      started = 0;
    end
    if (k < N - 1) st[k+1] = started;
    cyc++;
  end

  // Compare DUT outputs with the model every cycle.
  always @(negedge clk) begin
    if (cyc >= N) begin
      bad++;
      $display("FAIL budget cyc=%0d got=overflow want=<%0d", cyc, N);
      $fatal(1, "cycle budget exhausted");
    end
    if (!n_rst) begin
      chk("rst_ready", {31'h0, byte_ready}, 32'h0);
      chk("rst_wv", {31'h0, word_valid}, 32'h0);
      chk("rst_clear", {31'h0, clear}, 32'h0);
      chk("rst_data", data_out, 32'h0);
    end else begin
      chk("ready", {31'h0, byte_ready},
          {31'h0, st[cyc] && !blk[cyc]});
      chk("wv", {31'h0, word_valid}, {31'h0, ew[cyc]});
      chk("data", data_out, ed[cyc]);
      chk("clear", {31'h0, clear}, {31'h0, ec[cyc]});
      if (clear) dclr++;
    end
  end

  task automatic send(input logic [7:0] b, input bit e);
    int t;
    bit got;
    byte_in = b;
    byte_eop = e;
    byte_valid = 1'b1;
    got = 0;
    t = 0;
    while (!got && t < 40) begin
      @(posedge clk);
      #1;
      got = last_xfer;
      t++;
    end
    if (!got) begin
      bad++;
      $display("FAIL send_timeout byte=%h got=none want=accept", b);
    end
    #1;
    byte_valid = 1'b0;
    byte_eop = 1'($urandom);
    byte_in = 8'($urandom);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_model();
    mwords.delete();
    mclr = 0;
    mzero = 0;
    dclr = 0;
  endtask

  task automatic check_pkt(input string nm, input int n,
                           input logic [31:0] w0,
                           input logic [31:0] w1,
                           input int nclr);
    idle(14);
    chk({nm, "_nwords"}, mwords.size(), n);
    if (mwords.size() > 0) chk({nm, "_w0"}, mwords[0], w0);
    if (n > 1 && mwords.size() > 1) chk({nm, "_w1"}, mwords[1], w1);
    chk({nm, "_mclr"}, mclr, nclr);
    chk({nm, "_zeros"}, mzero, nclr * FZ);
    chk({nm, "_dclr"}, dclr, nclr);
    clr_model();
  endtask

  initial begin
    int len;
    n_rst = 1'b0;
    byte_in = 8'h0;
    byte_valid = 1'b0;
    byte_eop = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_rst = 1'b1;
    idle(2);

    send(8'h11, 0);
    send(8'h22, 0);
    n_rst = 1'b0;
    #1;
    chk("midrst_wv", {31'h0, word_valid}, 32'h0);
    chk("midrst_clear", {31'h0, clear}, 32'h0);
    chk("midrst_data", data_out, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    n_rst = 1'b1;
    clr_model();
    send(8'h47, 0); send(8'h45, 0);
    send(8'h54, 0); send(8'h20, 1);
    check_pkt("get", 1, 32'h47455420, 32'h0, 1);

    send(8'h77, 0); send(8'h77, 0); send(8'h77, 0); send(8'h2E, 0);
    send(8'h70, 0); send(8'h75, 0); send(8'h72, 0); send(8'h64, 1);
    check_pkt("full", 2, 32'h7777772E, 32'h70757264, 1);

    send(8'h65, 0); send(8'h64, 0); send(8'h75, 1);
    check_pkt("partial", 1, 32'h65647500, 32'h0, 1);

    send(8'h0D, 0); idle(1); send(8'h0A, 0); idle(1);
    send(8'h0D, 0); idle(1); send(8'h0A, 1);
    check_pkt("gaps", 1, 32'h0D0A0D0A, 32'h0, 1);

    send(8'h61, 0); send(8'h62, 1); send(8'h63, 1);
    check_pkt("bp", 2, 32'h61620000, 32'h63000000, 2);

    send(8'h41, 1);
    check_pkt("single", 1, 32'h41000000, 32'h0, 1);

    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 11);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(8'($urandom), i == len - 1);
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end
    idle(14);
    chk("rand_dclr", dclr, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 The block SHALL have these ports:
 - clk  input  1  system clock, rising-edge active.
 - n_rst  input  1  asynchronous, active-low reset.
 - byte_in  input  8  packet byte from the MAC side.
 - byte_valid  input  1  byte_in is valid this cycle.
 - byte_eop  input  1  qualifies byte_in as the last byte of the packet; ignored when byte_valid=0.
 - byte_ready  output  1  block accepts a byte this cycle.
 - data_out  output  32  packed word toward the matcher's data_in.
 - word_valid  output  1  data_out holds a new word this cycle.
 - clear  output  1  one-cycle end-of-packet pulse toward the matcher's clear.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low (clk, n_rst).

Function
REQ-003 A byte transfer SHALL occur on a rising clk edge with byte_valid=1 and byte_ready=1.
REQ-004 Packing SHALL be big-endian: packet byte 0 goes to data_out[31:24] and byte 3 to [7:0].
REQ-005 A 2-bit lane counter SHALL advance once per transfer and wrap from 3 to 0.
REQ-006 On the 4th transfer of a word, the block SHALL register data_out and drive word_valid=1 for exactly the next cycle, giving a latency of 1 cycle.
REQ-007 A transfer with byte_eop=1 SHALL close the current word. Unfilled lower lanes SHALL be 0x00, and the word SHALL be emitted next cycle as in REQ-006.
REQ-008 When word_valid=0, data_out SHALL hold 32'h0.
REQ-009 The state machine SHALL have the states IDLE, FILL, FLUSH and CLR:
 - IDLE to FILL on the first transfer.
 - FILL to FLUSH (or to CLR, see REQ-016) on the eop transfer.
 - FLUSH to CLR after the flush words.
 - CLR to IDLE after one cycle.
REQ-010 byte_ready SHALL be 1 in IDLE and FILL, and 0 in FLUSH and CLR.
REQ-011 In CLR the block SHALL assert clear=1 for exactly one cycle. The lane counter and partial word SHALL then be zeroed.
REQ-012 If the eop byte is the 4th lane, no extra padding word SHALL be emitted; exactly one word SHALL carry that byte.
REQ-013 A packet of length 0 cannot exist. byte_eop with byte_valid=0 SHALL have no effect.
REQ-014 Gaps (byte_valid=0) in FILL SHALL hold the lane counter and partial word indefinitely, with no timeout.

Reset
REQ-015 While n_rst=0 the block SHALL hold these values:
 - state IDLE, lane counter 0, partial word 0.
 - data_out=32'h0, word_valid=0, clear=0, byte_ready=0.
 - byte_ready SHALL rise on the first clk edge after n_rst deasserts.
 - Assertion mid-packet SHALL discard the partial word, with no word_valid and no clear issued for it.

Configuration
REQ-016 The macro WORD_PACKER_FLUSH_EN SHALL select the end-of-packet behaviour.
 - Defined: after the final packet word, the block SHALL emit 5 words of 32'h0 with word_valid=1 on 5 consecutive cycles (FLUSH), then CLR. This drains the matcher's 5-word window.
 - Undefined: FLUSH SHALL be skipped. CLR SHALL follow the cycle after the final word.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
 - Reset: n_rst=0 mid-packet after 2 bytes -> word_valid=0, clear=0, data_out=0. After release, the bytes "GET " produce 32'h47455420 with no stale lanes.
 - Full-word packet: bytes 77 77 77 2E 70 75 72 64 with eop on 64 -> words 32'h7777772E then 32'h70757264. With flush: 5 zero words then a 1-cycle clear. Without flush: clear on the cycle after the second word.
 - Partial word: bytes 65 64 75 with eop on 75 -> 32'h65647500, then the flush/clear sequence.
 - Gaps: byte_valid toggled 1/0 across 4 bytes 0D 0A 0D 0A -> a single 32'h0D0A0D0A one cycle after the 4th transfer. word_valid stays 0 during gaps.
 - Backpressure: byte_valid held 1 through FLUSH/CLR -> byte_ready=0, and no byte is accepted until IDLE. The next packet starts at lane 0.
 - Single-byte packet: byte 41 with eop -> 32'h41000000, then clear exactly once.
